// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit (and later receive) path.
package uart_pkg;

    // Parity mode as carried by the PARITY parameter (0 = none, 1 = odd, 2 = even).
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Transmitter frame phases.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam int MAX_DATA_BITS  = 8;
    // start + data + parity + two stop bits
    localparam int MAX_FRAME_BITS = 1 + MAX_DATA_BITS + 1 + 2;
    localparam int BIT_CNT_W      = $clog2(MAX_FRAME_BITS);

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Map the integer parity parameter onto the enum; anything unknown means none.
    function automatic parity_e to_parity(input int mode);
        case (mode)
            1:       return PAR_ODD;
            2:       return PAR_EVEN;
            default: return PAR_NONE;
        endcase
    endfunction

    // Parity bit for a data word; unused upper bits must be zero.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input parity_e                  mode);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and flags the last clock of each bit.
// Shared between the transmitter and the future receiver.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running divider, held at zero while restart is asserted.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // pre-edge values and simulation ordering cannot change the result.
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fc.sv
// UART transmitter with CTS flow control: valid/ready byte input, framed as
// start, data LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fc
    import uart_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 115200,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int CTS_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 uart_cts,
    output logic                 uart_txd,
    output logic                 busy,
    output logic                 bit_tick
);

    localparam int      DIV           = calc_div(CLK_HZ, BAUD);
    localparam parity_e PAR_MODE      = to_parity(PARITY);
    localparam logic    CTS_NOT_CLEAR = (CTS_ACTIVE_LOW != 0);

    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot represent.
    if (DIV < 4) begin : g_bad_div
        $error("uart_tx_fc: clocks per bit (%0d) must be at least 4", DIV);
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_fc: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fc: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fc: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;
    logic                 cts_meta;
    logic                 cts_sync;
    logic                 cts_ok;
    logic                 accept;
    logic                 tick;

    // Two-flop synchroniser for the asynchronous CTS input; reset means "not clear".
    always_ff @(posedge clk) begin
        if (reset) begin
            cts_meta <= CTS_NOT_CLEAR;
            cts_sync <= CTS_NOT_CLEAR;
        end else begin
            cts_meta <= uart_cts;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok   = cts_sync ^ CTS_NOT_CLEAR;
    assign tx_ready = (state == TX_IDLE) && cts_ok && !reset;
    assign accept   = tx_valid && tx_ready;

    // Divider is parked at zero in IDLE, so the start bit always gets a full period.
    uart_bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(state == TX_IDLE),
        .tick   (tick)
    );

    assign bit_tick = tick && (state != TX_IDLE);

    // Frame sequencer: walks start, data, parity and stop bits, one per timer tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data shift register and parity flop are cleared too; they
            // are only read after an accept reloads them, but a defined value
            // keeps the register bank X-free for equivalence and gate sims.
            state    <= TX_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            uart_txd <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (accept) begin
                        shreg    <= tx_data;
                        par_q    <= parity_bit(MAX_DATA_BITS'(tx_data), PAR_MODE);
                        bit_cnt  <= '0;
                        uart_txd <= 1'b0;
                        busy     <= 1'b1;
                        state    <= TX_START;
                    end
                end

                TX_START: begin
                    if (tick) begin
                        uart_txd <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_cnt  <= '0;
                        state    <= TX_DATA;
                    end
                end

                TX_DATA: begin
                    if (tick) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PAR_MODE != PAR_NONE) begin
                                uart_txd <= par_q;
                                state    <= TX_PARITY;
                            end else begin
                                uart_txd <= 1'b1;
                                state    <= TX_STOP;
                            end
                        end else begin
                            uart_txd <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                TX_PARITY: begin
                    if (tick) begin
                        uart_txd <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= TX_STOP;
                    end
                end

                TX_STOP: begin
                    if (tick) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= TX_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    uart_txd <= 1'b1;
                    busy     <= 1'b0;
                    bit_cnt  <= '0;
                    state    <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fc.sv
// Bench for uart_tx_fc: five configurations run side by side against a
// cycle-count frame model, plus hand-computed frame captures.
module tb_uart_tx_fc;

    localparam int N = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     tx_valid;
    logic [N-1:0]     uart_cts;
    logic [N-1:0]     txd;
    logic [N-1:0]     busy;
    logic [N-1:0]     tick;
    logic [N-1:0]     ready;
    logic [7:0]       tx_data_v [N];
    logic             chk_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N2 (all 10 clocks per bit), u4: defaults.
    uart_tx_fc #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .reset(reset), .tx_data(tx_data_v[0]), .tx_valid(tx_valid[0]),
        .tx_ready(ready[0]), .uart_cts(uart_cts[0]), .uart_txd(txd[0]),
        .busy(busy[0]), .bit_tick(tick[0]));

    uart_tx_fc #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u1 (.clk(clk), .reset(reset), .tx_data(tx_data_v[1]), .tx_valid(tx_valid[1]),
        .tx_ready(ready[1]), .uart_cts(uart_cts[1]), .uart_txd(txd[1]),
        .busy(busy[1]), .bit_tick(tick[1]));

    uart_tx_fc #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u2 (.clk(clk), .reset(reset), .tx_data(tx_data_v[2]), .tx_valid(tx_valid[2]),
        .tx_ready(ready[2]), .uart_cts(uart_cts[2]), .uart_txd(txd[2]),
        .busy(busy[2]), .bit_tick(tick[2]));

    uart_tx_fc #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u3 (.clk(clk), .reset(reset), .tx_data(tx_data_v[3][6:0]), .tx_valid(tx_valid[3]),
        .tx_ready(ready[3]), .uart_cts(uart_cts[3]), .uart_txd(txd[3]),
        .busy(busy[3]), .bit_tick(tick[3]));

    uart_tx_fc u4 (.clk(clk), .reset(reset), .tx_data(tx_data_v[4]), .tx_valid(tx_valid[4]),
        .tx_ready(ready[4]), .uart_cts(uart_cts[4]), .uart_txd(txd[4]),
        .busy(busy[4]), .bit_tick(tick[4]));

    // Per-instance line configuration as the model sees it.
    function automatic int cfg_div(input int i);
        return (i == 4) ? 434 : 10;
    endfunction
    function automatic int cfg_ndb(input int i);
        return (i == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_nstop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int frame_bits(input int i);
        return 1 + cfg_ndb(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_nstop(i);
    endfunction

    // Line levels of a whole frame, bit k = k-th bit period on the wire.
    function automatic logic [11:0] build_frame(input int i, input logic [7:0] d);
        logic [11:0] f;
        int          ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int b = 0; b < cfg_ndb(i); b++) begin
            f[1 + b] = d[b];
            ones += int'(d[b]);
        end
        if (cfg_par(i) == 1)      f[1 + cfg_ndb(i)] = (ones % 2 == 0);
        else if (cfg_par(i) == 2) f[1 + cfg_ndb(i)] = (ones % 2 == 1);
        return f;
    endfunction

    // Model: m_pos = cycles since the accept edge (-1 when idle); m_hist holds
    // "clear to send" as seen one and two edges ago.
    int          m_pos   [N];
    logic [11:0] m_frame [N];
    logic [1:0]  m_hist  [N];

    function automatic logic exp_ready(input int i);
        return (m_pos[i] < 0) && m_hist[i][1] && !reset;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_pos[i]  <= -1;
                m_hist[i] <= 2'b00;
            end else begin
                m_hist[i] <= {m_hist[i][0], !uart_cts[i]};
                if (m_pos[i] < 0) begin
                    if (tx_valid[i] && exp_ready(i)) begin
                        m_pos[i]   <= 0;
                        m_frame[i] <= build_frame(i, tx_data_v[i]);
                    end
                end else if (m_pos[i] == frame_bits(i) * cfg_div(i) - 1) begin
                    m_pos[i] <= -1;
                end else begin
                    m_pos[i] <= m_pos[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Every cycle, every instance: {txd, busy, bit_tick, tx_ready} against the model.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                logic [3:0] e;
                int         p;
                p = m_pos[i];
                if (p < 0) e = {1'b1, 1'b0, 1'b0, exp_ready(i)};
                else       e = {m_frame[i][p / cfg_div(i)], 1'b1,
                                (p % cfg_div(i) == cfg_div(i) - 1), exp_ready(i)};
                check($sformatf("cycle_u%0d {txd,busy,tick,ready}", i),
                      16'({txd[i], busy[i], tick[i], ready[i]}), 16'(e));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i);
        int w;
        w = 0;
        while (!ready[i] && w < 100) begin
            step();
            w++;
        end
        check($sformatf("ready_seen_u%0d", i), 16'(ready[i]), 16'(1));
    endtask

    // Starts on the first cycle of a frame; samples txd mid-bit until busy drops.
    task automatic capture(input int i, output int len, output logic [11:0] bits,
                           output int ticks);
        len   = 0;
        bits  = '0;
        ticks = 0;
        while (busy[i] && len < 6000) begin
            if (len % cfg_div(i) == cfg_div(i) / 2) bits[len / cfg_div(i)] = txd[i];
            ticks += int'(tick[i]);
            len++;
            step();
        end
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input logic [11:0] exp_bits,
                              input int exp_len, input int exp_ticks);
        int          len;
        int          ticks;
        logic [11:0] bits;
        tx_data_v[i] = d;
        tx_valid[i]  = 1'b1;
        wait_ready(i);
        step();
        tx_valid[i] = 1'b0;
        capture(i, len, bits, ticks);
        check($sformatf("frame_bits_u%0d_%02h", i, d), 16'(bits), 16'(exp_bits));
        check($sformatf("frame_len_u%0d_%02h", i, d), 16'(len), 16'(exp_len));
        check($sformatf("frame_ticks_u%0d_%02h", i, d), 16'(ticks), 16'(exp_ticks));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        int          hi;
        int          len;
        int          ticks;
        logic [11:0] bits;

        tx_valid = '0;
        uart_cts = '0;
        for (int i = 0; i < N; i++) tx_data_v[i] = 8'h00;

        // Reset held for three edges with CTS clear.
        step();
        chk_en = 1'b1;
        check("reset_c1 {txd,busy,ready}", 16'({txd[0], busy[0], ready[0]}), 16'(3'b100));
        step();
        check("reset_c2 {txd,busy,ready}", 16'({txd[0], busy[0], ready[0]}), 16'(3'b100));
        step();
        check("reset_c3 {txd,busy,ready}", 16'({txd[0], busy[0], ready[0]}), 16'(3'b100));
        reset = 1'b0;
        step();
        check("ready_1st_after_release", 16'(ready[0]), 16'(0));
        step();
        check("ready_2nd_after_release", 16'(ready[0]), 16'(1));

        // Single frames on each short-period configuration.
        send_frame(0, 8'hA5, 12'h34A, 100, 10);
        send_frame(1, 8'hA5, 12'h54A, 110, 11);
        send_frame(2, 8'hA5, 12'h74A, 110, 11);
        send_frame(3, 8'h41, 12'h382, 100, 10);

        // Flow control: blocked while not clear, released two cycles after CTS drops.
        uart_cts[0] = 1'b1;
        step();
        step();
        tx_data_v[0] = 8'h3C;
        tx_valid[0]  = 1'b1;
        hi = 0;
        repeat (20) begin
            step();
            if (ready[0] || busy[0] || !txd[0]) hi++;
        end
        check("cts_blocked_activity", 16'(hi), 16'(0));
        uart_cts[0] = 1'b0;
        w = 0;
        while (!ready[0] && w < 10) begin
            step();
            w++;
        end
        check("cts_to_ready_latency", 16'(w), 16'(2));
        step();
        check("cts_accept_busy", 16'(busy[0]), 16'(1));
        tx_data_v[0] = 8'h99;
        repeat (30) step();
        uart_cts[0] = 1'b1;
        w = 0;
        while (busy[0] && w < 200) begin
            step();
            w++;
        end
        check("cts_midframe_remaining", 16'(w), 16'(70));
        hi = 0;
        repeat (20) begin
            step();
            if (busy[0] || ready[0]) hi++;
        end
        check("cts_next_held", 16'(hi), 16'(0));
        tx_valid[0] = 1'b0;
        uart_cts[0] = 1'b0;
        repeat (3) step();

        // Back-to-back 0x00 then 0xFF with valid held throughout.
        tx_data_v[0] = 8'h00;
        tx_valid[0]  = 1'b1;
        wait_ready(0);
        step();
        tx_data_v[0] = 8'hFF;
        capture(0, len, bits, ticks);
        check("b2b_first_bits", 16'(bits), 16'(12'h200));
        check("b2b_first_len", 16'(len), 16'(100));
        w = 0;
        while (!busy[0] && w < 50) begin
            w++;
            step();
        end
        check("b2b_idle_gap", 16'(w), 16'(1));
        tx_valid[0] = 1'b0;
        capture(0, len, bits, ticks);
        check("b2b_second_bits", 16'(bits), 16'(12'h3FE));
        check("b2b_second_len", 16'(len), 16'(100));

        // Reset during data bit 3 aborts the frame; the next frame is whole.
        tx_data_v[0] = 8'hA5;
        tx_valid[0]  = 1'b1;
        wait_ready(0);
        step();
        tx_valid[0] = 1'b0;
        repeat (45) step();
        check("pre_reset_txd_bit3", 16'(txd[0]), 16'(0));
        reset = 1'b1;
        step();
        check("reset_abort {txd,busy}", 16'({txd[0], busy[0]}), 16'(2'b10));
        reset = 1'b0;
        send_frame(0, 8'hC3, 12'h386, 100, 10);

        // Default parameters: 434 clocks per bit, 8N1.
        send_frame(4, 8'h55, 12'h2AA, 4340, 10);

        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
